// File: rtl/slc3_mem_responder_if.sv
// ---------------------------------------------------------------------------
// slc3_mem_responder_if
// CPU-side memory bus between the SLC-3 control unit/MAR/MDR and the memory
// responder.
//   Mem_OE, Mem_WE   : read / write request strobes, active high
//   ADDR             : word address from MAR
//   Data_from_CPU    : write data from MDR
//   Data_to_CPU      : read data toward MDR
//   Mem_Ready        : one-cycle access-complete pulse
// modport master : CPU datapath side
// modport slave  : memory responder side
// ---------------------------------------------------------------------------
interface slc3_mem_responder_if #(
  parameter int ADDR_W = 16
);
  logic              Mem_OE;
  logic              Mem_WE;
  logic [ADDR_W-1:0] ADDR;
  logic [15:0]       Data_from_CPU;
  logic [15:0]       Data_to_CPU;
  logic              Mem_Ready;

  modport master (
    output Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    input  Data_to_CPU, Mem_Ready
  );

  modport slave (
    input  Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    output Data_to_CPU, Mem_Ready
  );
endinterface

// File: rtl/slc3_mem_responder.sv
// ---------------------------------------------------------------------------
// slc3_mem_responder
// Memory-side responder for the SLC-3 datapath. Turns the control unit's
// Mem_OE/Mem_WE strobes into an async SRAM cycle with configurable wait
// states, returns read data with a one-cycle Mem_Ready pulse, and decodes one
// memory-mapped I/O word (switches in, hex display register out).
//
// Ports:
//   Clk, Reset        : clock, asynchronous active-high reset
//   bus (slave)       : CPU-side request/response bus (see _if file)
//   Switches          : board switches, read at IO_ADDR
//   Hex_Out           : display register, written at IO_ADDR
//   SRAM_ADDR         : registered SRAM address
//   SRAM_CE_N/OE_N/WE_N/UB_N/LB_N : SRAM strobes, active low
//   SRAM_DQ_IN        : SRAM data bus input
//   SRAM_DQ_OUT       : SRAM data bus drive value
//   SRAM_DQ_OE        : 1 = drive SRAM_DQ_OUT onto the bus
// ---------------------------------------------------------------------------
module slc3_mem_responder #(
  parameter int                ADDR_W     = 16,
  parameter int                READ_WAIT  = 2,
  parameter int                WRITE_WAIT = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR    = ADDR_W'(16'hFFFF)
) (
  input  logic                Clk,
  input  logic                Reset,
  slc3_mem_responder_if.slave bus,
  input  logic [15:0]         Switches,
  output logic [15:0]         Hex_Out,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  input  logic [15:0]         SRAM_DQ_IN,
  output logic [15:0]         SRAM_DQ_OUT,
  output logic                SRAM_DQ_OE
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // The counter is loaded with wait-1 so the wait state lasts exactly
  // READ_WAIT / WRITE_WAIT cycles before it reads zero and moves on.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_LATCH,
    WR_PULSE,
    WR_HOLD,
    IO_ACK,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      rd_data_q;
  logic [15:0]      hex_q;
  logic             req;
  logic             is_io;
  logic             ready;

  assign req   = bus.Mem_OE | bus.Mem_WE;
  assign is_io = (bus.ADDR == IO_ADDR);

  assign bus.Data_to_CPU = rd_data_q;
  assign bus.Mem_Ready   = ready;
  assign Hex_Out         = hex_q;

  // State register and datapath. Address and write data are captured only at
  // acceptance in IDLE, so later MAR/MDR changes cannot disturb the cycle.
  // Read data is sampled as the last wait cycle ends, so it is already valid
  // on Data_to_CPU while Mem_Ready is high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      rd_data_q   <= '0;
      hex_q       <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (req) begin
            SRAM_ADDR   <= bus.ADDR;
            SRAM_DQ_OUT <= bus.Data_from_CPU;
            wait_cnt    <= bus.Mem_WE ? WR_LOAD : RD_LOAD;
            if (is_io) begin
              if (bus.Mem_WE) begin
                hex_q <= bus.Data_from_CPU;
              end else begin
                rd_data_q <= Switches;
              end
            end
          end
        end
        RD_WAIT: begin
          if (wait_cnt == '0) begin
            rd_data_q <= SRAM_DQ_IN;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        WR_PULSE: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and SRAM strobes. The strobes decode straight from the state
  // register, so an asynchronous reset drops every SRAM strobe at once
  // without waiting for a clock edge. Write (DQ_OE) and read (OE_N low)
  // states are disjoint, so the bus is never contended.
  always_comb begin
    next_state = state;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_DQ_OE = 1'b0;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (is_io) begin
            next_state = IO_ACK;
          end else if (bus.Mem_WE) begin
            next_state = WR_PULSE;
          end else begin
            next_state = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        if (wait_cnt == '0) begin
          next_state = RD_LATCH;
        end
      end
      RD_LATCH: begin
        SRAM_CE_N  = 1'b0;
        SRAM_OE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        ready      = 1'b1;
        next_state = DONE;
      end
      WR_PULSE: begin
        SRAM_CE_N  = 1'b0;
        SRAM_WE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        SRAM_DQ_OE = 1'b1;
        if (wait_cnt == '0) begin
          next_state = WR_HOLD;
        end
      end
      WR_HOLD: begin
        // WE_N has risen; CE_N and the data drive stay on for hold time.
        SRAM_CE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        SRAM_DQ_OE = 1'b1;
        ready      = 1'b1;
        next_state = DONE;
      end
      IO_ACK: begin
        ready      = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        // A strobe held high must be released before another access starts.
        if (!req) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: doc/slc3_mem_responder.md
Name: slc3_mem_responder

Overview:
Memory-side responder for the SLC-3 datapath. Accepts the active-high Mem_OE/Mem_WE strobes and address/data that the control unit and MAR/MDR present, and runs the external async SRAM cycle with configurable wait states. It returns read data plus a one-cycle ready pulse, and decodes one memory-mapped I/O word (switches in, hex display register out). Sits between the CPU datapath and the board SRAM pins.

Parameters:
ADDR_W, 16, address width (SLC-3 word address)
READ_WAIT, 2, cycles SRAM_OE_N held low before read data is sampled (>=1)
WRITE_WAIT, 2, cycles SRAM_WE_N held low per write (>=1)
IO_ADDR, 16'hFFFF, address decoded as memory-mapped I/O instead of SRAM

Ports:
Clk  in  1  system clock; all state on rising edge
Reset  in  1  asynchronous, active-high reset
Mem_OE  in  1  read request from control unit, active high
Mem_WE  in  1  write request from control unit, active high
ADDR  in  ADDR_W  word address from MAR
Data_from_CPU  in  16  write data from MDR
Switches  in  16  board switches, read at IO_ADDR
Data_to_CPU  out  16  read data toward MDR, held until next read completes
Mem_Ready  out  1  one-cycle pulse: access complete
Hex_Out  out  16  display register, written at IO_ADDR
SRAM_ADDR  out  ADDR_W  registered SRAM address
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM strobes, active low
SRAM_DQ_IN  in  16  SRAM data bus input
SRAM_DQ_OUT  out  16  SRAM data bus drive value
SRAM_DQ_OE  out  1  1 = drive SRAM_DQ_OUT onto the bus (tristate at top level)

Behaviour:
- Reset (async, any state): state IDLE; Data_to_CPU=0, Hex_Out=0, Mem_Ready=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, SRAM_DQ_OE=0. All SRAM_*_N=1 immediately, without waiting for a clock edge. An aborted write is not retried.
- States: IDLE, RD_WAIT, RD_LATCH, WR_PULSE, WR_HOLD, IO_ACK, DONE.
- IDLE: samples strobes each edge. Mem_WE=1 has priority over Mem_OE; both=1 is treated as a write. On acceptance, ADDR is captured into SRAM_ADDR and Data_from_CPU into SRAM_DQ_OUT. ADDR/data changes after acceptance are ignored.
- Any accepted strobe with ADDR==IO_ADDR -> IO_ACK; no SRAM strobe asserts.
  - Read: Data_to_CPU<=Switches.
  - Write: Hex_Out<=Data_from_CPU.
  - Mem_Ready=1 in IO_ACK, then DONE.
- SRAM read: RD_WAIT for READ_WAIT cycles with CE_N=OE_N=UB_N=LB_N=0, WE_N=1, DQ_OE=0; wait counter counts down to 0. RD_LATCH: Data_to_CPU<=SRAM_DQ_IN, Mem_Ready=1, OE_N still 0; then DONE.
- SRAM write: WR_PULSE for WRITE_WAIT cycles with CE_N=WE_N=UB_N=LB_N=0, OE_N=1, DQ_OE=1. WR_HOLD: WE_N=1, CE_N=0, DQ_OE=1 (data hold), Mem_Ready=1; then DONE.
- Latency, strobe accepted at edge 0: SRAM read Mem_Ready high in cycle READ_WAIT+1 (default 3). SRAM write in cycle WRITE_WAIT+1 (default 3). I/O in cycle 1.
- DONE: all SRAM strobes inactive, DQ_OE=0. Stays in DONE while Mem_OE|Mem_WE; goes to IDLE on the first edge both are 0. A strobe held high therefore never retriggers a second access.
- Mem_Ready is exactly one cycle per access, never asserted in IDLE or DONE.
- DQ_OE and OE_N=0 are never asserted in the same cycle (no bus contention).
- Strobes arriving while not in IDLE are ignored except as DONE exit gating.

Test Plan:
- Reset, then SRAM model word 0x0040=16'hBEEF; Mem_OE=1, ADDR=0x0040 held -> OE_N low 3 cycles, Data_to_CPU=16'hBEEF, Mem_Ready pulses once in cycle 3, no second access while OE stays high.
- Mem_WE=1, ADDR=0x1234, Data_from_CPU=16'hA5A5 -> WE_N low exactly 2 cycles with DQ_OE=1, SRAM model holds 16'hA5A5, Mem_Ready in cycle 3; a read back of 0x1234 returns 16'hA5A5.
- Switches=16'h00C3, read ADDR=16'hFFFF -> Data_to_CPU=16'h00C3 with Mem_Ready in cycle 1 and SRAM_CE_N=1 throughout. Write 16'h0042 to 16'hFFFF -> Hex_Out=16'h0042 and SRAM untouched.
- Mem_OE=Mem_WE=1 with ADDR=0x0002, data 16'h1111 -> write performed, OE_N never low, SRAM[2]=16'h1111.
- Assert Reset asynchronously mid-WR_PULSE -> WE_N, CE_N=1 and DQ_OE=0 before the next Clk edge, Mem_Ready never pulses, a subsequent read completes normally.
- Rebuild with READ_WAIT=4, WRITE_WAIT=1 -> read Mem_Ready in cycle 5, write WE_N low 1 cycle, Mem_Ready in cycle 2.
